// File: rtl/sha_job_controller_if.sv
// Host-side job/result bundle for the SHA job controller.
// Latency: none, wires only.
// Backpressure: job_valid/job_ready on the job side, res_valid/res_ready on the result side.
interface sha_job_controller_if;
    logic         job_valid;
    logic         job_ready;
    logic [255:0] job_mid;
    logic [511:0] job_head;
    logic         abort;
    logic         res_valid;
    logic         res_ready;
    logic         res_found;
    logic [31:0]  res_nonce;
    logic         busy;

    // Host side: offers jobs, consumes results.
    modport master (
        output job_valid, job_mid, job_head, abort, res_ready,
        input  job_ready, res_valid, res_found, res_nonce, busy
    );

    // Controller side.
    modport slave (
        input  job_valid, job_mid, job_head, abort, res_ready,
        output job_ready, res_valid, res_found, res_nonce, busy
    );
endinterface

// File: rtl/sha_job_controller.sv
// Sequences one sha_block through load, search and report for each mining job.
// Latency: accept->first solve_en 2 cycles; flag->res_valid 1 cycle.
// Backpressure: jobs accepted only in IDLE; result held stable until res_ready.
module sha_job_controller #(
    parameter logic [31:0] SEARCH_LIMIT = 32'hFFFF_FFFF,
    parameter int unsigned WARMUP       = 2
) (
    input  logic                 clk,
    input  logic                 n_rst,
    sha_job_controller_if.slave  host,
    output logic [255:0]         mid_state,
    output logic [511:0]         head_data,
    output logic                 load_state,
    output logic                 solve_en,
    input  logic                 sha_flag,
    input  logic [31:0]          sha_nonce
);

    typedef enum logic [1:0] {IDLE, LOAD, SOLVE, REPORT} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] cycle_cnt;
    logic [3:0]  warm_cnt;
    logic        capture;
    logic        found_nxt;
    logic [31:0] nonce_nxt;

    // Ready is a pure state decode; gated by reset so it reads 0 while reset is held.
    assign host.job_ready = (state == IDLE) && n_rst;

    // Next-state decode with SOLVE exit priority abort > flag > limit.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        found_nxt = 1'b0;
        nonce_nxt = 32'd0;
        case (state)
            IDLE: begin
                if (host.job_valid) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = SOLVE;
            end
            SOLVE: begin
                if (host.abort) begin
                    state_nxt = REPORT;
                    capture   = 1'b1;
                end else if (sha_flag && (warm_cnt == 4'd0)) begin
                    state_nxt = REPORT;
                    capture   = 1'b1;
                    found_nxt = 1'b1;
                    nonce_nxt = sha_nonce;
                end else if (cycle_cnt == (SEARCH_LIMIT - 32'd1)) begin
                    state_nxt = REPORT;
                    capture   = 1'b1;
                end
            end
            REPORT: begin
                if (host.res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Job capture: data is frozen from accept until the next accept.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mid_state <= '0;
            head_data <= '0;
        end else if ((state == IDLE) && host.job_valid) begin
            mid_state <= host.job_mid;
            head_data <= host.job_head;
        end
    end

    // Search cycle counter and warmup mask; SOLVE exits at the limit so the count never wraps.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cycle_cnt <= 32'd0;
            warm_cnt  <= 4'd0;
        end else if (state == LOAD) begin
            cycle_cnt <= 32'd0;
            warm_cnt  <= 4'(WARMUP);
        end else if (state == SOLVE) begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (warm_cnt != 4'd0) begin
                warm_cnt <= warm_cnt - 4'd1;
            end
        end
    end

    // Registered outputs decoded from the upcoming state so they align with it.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            load_state     <= 1'b0;
            solve_en       <= 1'b0;
            host.res_valid <= 1'b0;
            host.busy      <= 1'b0;
            host.res_found <= 1'b0;
            host.res_nonce <= 32'd0;
        end else begin
            load_state     <= (state_nxt == SOLVE);
            solve_en       <= (state_nxt == SOLVE);
            host.res_valid <= (state_nxt == REPORT);
            host.busy      <= (state_nxt != IDLE);
            if (capture) begin
                host.res_found <= found_nxt;
                host.res_nonce <= nonce_nxt;
            end else if ((state == REPORT) && host.res_ready) begin
                host.res_found <= 1'b0;
                host.res_nonce <= 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_sha_job_controller.sv
// Directed bench for sha_job_controller: two instances (limit 100 and limit 8).
// Stimulus driven 1 time unit after each rising edge; outputs sampled at the same point.
// The instance under test is chosen by sel; the other one sees no stimulus.
module tb_sha_job_controller;

    logic         clk;
    logic         n_rst;
    logic         sel;
    logic         job_valid;
    logic [255:0] job_mid;
    logic [511:0] job_head;
    logic         abort;
    logic         res_ready;
    logic         sha_flag;
    logic [31:0]  sha_nonce;

    int n_compared;
    int n_mismatched;

    sha_job_controller_if bus_a ();
    sha_job_controller_if bus_b ();

    logic [255:0] mid_a, mid_b;
    logic [511:0] head_a, head_b;
    logic         load_a, load_b, solve_a, solve_b;

    assign bus_a.job_valid = job_valid & ~sel;
    assign bus_a.job_mid   = job_mid;
    assign bus_a.job_head  = job_head;
    assign bus_a.abort     = abort & ~sel;
    assign bus_a.res_ready = res_ready & ~sel;
    assign bus_b.job_valid = job_valid & sel;
    assign bus_b.job_mid   = job_mid;
    assign bus_b.job_head  = job_head;
    assign bus_b.abort     = abort & sel;
    assign bus_b.res_ready = res_ready & sel;

    sha_job_controller #(.SEARCH_LIMIT(32'd100), .WARMUP(2)) dut_a (
        .clk(clk), .n_rst(n_rst), .host(bus_a.slave),
        .mid_state(mid_a), .head_data(head_a), .load_state(load_a), .solve_en(solve_a),
        .sha_flag(sha_flag & ~sel), .sha_nonce(sha_nonce)
    );

    sha_job_controller #(.SEARCH_LIMIT(32'd8), .WARMUP(2)) dut_b (
        .clk(clk), .n_rst(n_rst), .host(bus_b.slave),
        .mid_state(mid_b), .head_data(head_b), .load_state(load_b), .solve_en(solve_b),
        .sha_flag(sha_flag & sel), .sha_nonce(sha_nonce)
    );

    wire          o_job_ready = sel ? bus_b.job_ready : bus_a.job_ready;
    wire          o_res_valid = sel ? bus_b.res_valid : bus_a.res_valid;
    wire          o_res_found = sel ? bus_b.res_found : bus_a.res_found;
    wire [31:0]   o_res_nonce = sel ? bus_b.res_nonce : bus_a.res_nonce;
    wire          o_busy      = sel ? bus_b.busy      : bus_a.busy;
    wire [255:0]  o_mid       = sel ? mid_b           : mid_a;
    wire [511:0]  o_head      = sel ? head_b          : head_a;
    wire          o_load      = sel ? load_b          : load_a;
    wire          o_solve     = sel ? solve_b         : solve_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a job from IDLE; returns in SOLVE cycle 0.
    task automatic start_job(input logic [255:0] mid, input logic [511:0] head);
        job_mid   = mid;
        job_head  = head;
        job_valid = 1'b1;
        step();
        job_valid = 1'b0;
        step();
    endtask

    task automatic consume();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        #23;
        n_compared++; if (o_job_ready !== 1'b0) begin n_mismatched++; $display("FAIL rst_job_ready: got %b want 0", o_job_ready); end
        n_compared++; if ({o_load, o_solve, o_res_valid, o_res_found, o_busy} !== 5'b0) begin n_mismatched++; $display("FAIL rst_ctrl: got %b want 00000", {o_load, o_solve, o_res_valid, o_res_found, o_busy}); end
        n_compared++; if (o_res_nonce !== 32'd0) begin n_mismatched++; $display("FAIL rst_nonce: got %h want 0", o_res_nonce); end
        n_compared++; if ((o_mid !== 256'd0) || (o_head !== 512'd0)) begin n_mismatched++; $display("FAIL rst_data: mid %h want 0", o_mid); end
        n_rst = 1'b1;
        step();
        n_compared++; if ({o_job_ready, o_busy} !== 2'b10) begin n_mismatched++; $display("FAIL idle_after_rst: got %b want 10", {o_job_ready, o_busy}); end
    endtask

    task automatic test_found();
        logic [255:0] mid;
        logic [511:0] head;
        mid  = {8{32'hA5A5_0001}};
        head = {16{32'h5A5A_0002}};
        job_mid = mid; job_head = head; job_valid = 1'b1;
        step();
        job_valid = 1'b0;
        n_compared++; if ({o_load, o_solve, o_busy, o_job_ready} !== 4'b0010) begin n_mismatched++; $display("FAIL found_load: got %b want 0010", {o_load, o_solve, o_busy, o_job_ready}); end
        n_compared++; if ((o_mid !== mid) || (o_head !== head)) begin n_mismatched++; $display("FAIL found_latch: mid %h want %h", o_mid, mid); end
        step();
        n_compared++; if ({o_load, o_solve} !== 2'b11) begin n_mismatched++; $display("FAIL found_solve0: got %b want 11", {o_load, o_solve}); end
        repeat (5) step();
        sha_flag = 1'b1; sha_nonce = 32'h1234_ABCD;
        step();
        sha_flag = 1'b0; sha_nonce = 32'd0;
        n_compared++; if ({o_res_valid, o_res_found, o_solve, o_load} !== 4'b1100) begin n_mismatched++; $display("FAIL found_report: got %b want 1100", {o_res_valid, o_res_found, o_solve, o_load}); end
        n_compared++; if (o_res_nonce !== 32'h1234_ABCD) begin n_mismatched++; $display("FAIL found_nonce: got %h want 1234abcd", o_res_nonce); end
        consume();
        n_compared++; if ({o_res_valid, o_job_ready, o_busy} !== 3'b010) begin n_mismatched++; $display("FAIL found_idle: got %b want 010", {o_res_valid, o_job_ready, o_busy}); end
    endtask

    task automatic test_warmup();
        int n;
        start_job({8{32'h0000_1111}}, {16{32'h2222_0000}});
        n = 0;
        while ((o_solve === 1'b1) && (n < 300)) begin
            sha_flag  = (n < 2);
            sha_nonce = 32'hDEAD_BEEF;
            n++;
            step();
        end
        sha_flag = 1'b0; sha_nonce = 32'd0;
        n_compared++; if (n !== 100) begin n_mismatched++; $display("FAIL warmup_cycles: got %0d want 100", n); end
        n_compared++; if ({o_res_valid, o_res_found} !== 2'b10) begin n_mismatched++; $display("FAIL warmup_result: got %b want 10", {o_res_valid, o_res_found}); end
        n_compared++; if (o_res_nonce !== 32'd0) begin n_mismatched++; $display("FAIL warmup_nonce: got %h want 0", o_res_nonce); end
        consume();
    endtask

    task automatic test_tie();
        int n;
        sel = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            start_job({8{32'h0000_0B0B}}, {16{32'hC0C0_0000}});
            n = 0;
            while ((o_solve === 1'b1) && (n < 50)) begin
                sha_flag  = (pass == 0) && (n == 7);
                sha_nonce = 32'hCAFE_0007;
                n++;
                step();
            end
            sha_flag = 1'b0; sha_nonce = 32'd0;
            n_compared++; if (n !== 8) begin n_mismatched++; $display("FAIL tie_cycles pass %0d: got %0d want 8", pass, n); end
            n_compared++; if ({o_res_valid, o_res_found} !== ((pass == 0) ? 2'b11 : 2'b10)) begin n_mismatched++; $display("FAIL tie_found pass %0d: got %b", pass, {o_res_valid, o_res_found}); end
            n_compared++; if (o_res_nonce !== ((pass == 0) ? 32'hCAFE_0007 : 32'd0)) begin n_mismatched++; $display("FAIL tie_nonce pass %0d: got %h", pass, o_res_nonce); end
            consume();
        end
        sel = 1'b0;
        step();
    endtask

    task automatic test_abort();
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_compared++; if ({o_job_ready, o_busy} !== 2'b10) begin n_mismatched++; $display("FAIL abort_idle: got %b want 10", {o_job_ready, o_busy}); end
        start_job({8{32'h3333_0003}}, {16{32'h4444_0004}});
        repeat (3) step();
        abort = 1'b1; sha_flag = 1'b1; sha_nonce = 32'h5555_5555;
        step();
        abort = 1'b0; sha_flag = 1'b0; sha_nonce = 32'd0;
        n_compared++; if ({o_res_valid, o_res_found, o_solve} !== 3'b100) begin n_mismatched++; $display("FAIL abort_flag: got %b want 100", {o_res_valid, o_res_found, o_solve}); end
        n_compared++; if (o_res_nonce !== 32'd0) begin n_mismatched++; $display("FAIL abort_nonce: got %h want 0", o_res_nonce); end
        consume();
        start_job({8{32'h6666_0006}}, {16{32'h7777_0007}});
        repeat (4) step();
        sha_flag = 1'b1; sha_nonce = 32'h0BAD_F00D;
        step();
        sha_flag = 1'b0; sha_nonce = 32'd0;
        abort = 1'b1;
        repeat (3) step();
        n_compared++; if ({o_res_valid, o_res_found, o_res_nonce} !== {2'b11, 32'h0BAD_F00D}) begin n_mismatched++; $display("FAIL abort_in_report: got %b %h want 11 0badf00d", {o_res_valid, o_res_found}, o_res_nonce); end
        consume();
        abort = 1'b0;
        n_compared++; if ({o_res_valid, o_job_ready, o_busy} !== 3'b010) begin n_mismatched++; $display("FAIL abort_done: got %b want 010", {o_res_valid, o_job_ready, o_busy}); end
    endtask

    task automatic test_backpressure();
        logic [255:0] mid;
        int bad;
        mid = {8{32'h8888_0008}};
        start_job(mid, {16{32'h9999_0009}});
        repeat (2) step();
        sha_flag = 1'b1; sha_nonce = 32'h0000_0077;
        step();
        sha_flag = 1'b0; sha_nonce = 32'd0;
        job_mid = {8{32'hFFFF_0000}}; job_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if ({o_res_valid, o_res_found, o_job_ready, o_busy} !== 4'b1101) bad++;
            if ((o_res_nonce !== 32'h0000_0077) || (o_mid !== mid)) bad++;
            step();
        end
        n_compared++; if (bad !== 0) begin n_mismatched++; $display("FAIL bp_stable: %0d unstable samples, want 0", bad); end
        job_valid = 1'b0;
        consume();
        n_compared++; if ({o_job_ready, o_busy, o_mid} !== {2'b10, mid}) begin n_mismatched++; $display("FAIL bp_no_accept: got %b mid %h", {o_job_ready, o_busy}, o_mid); end
    endtask

    task automatic test_async_reset();
        start_job({8{32'h1212_3434}}, {16{32'h5656_7878}});
        repeat (3) step();
        #2;
        n_rst = 1'b0;
        #1;
        n_compared++; if ({o_load, o_solve, o_busy, o_res_valid, o_job_ready} !== 5'b0) begin n_mismatched++; $display("FAIL arst_ctrl: got %b want 00000", {o_load, o_solve, o_busy, o_res_valid, o_job_ready}); end
        n_compared++; if (o_mid !== 256'd0) begin n_mismatched++; $display("FAIL arst_mid: got %h want 0", o_mid); end
        @(negedge clk);
        n_rst = 1'b1;
        step();
        n_compared++; if ({o_res_valid, o_busy, o_job_ready} !== 3'b001) begin n_mismatched++; $display("FAIL arst_release: got %b want 001", {o_res_valid, o_busy, o_job_ready}); end
        job_mid = {8{32'h0101_0101}}; job_valid = 1'b1;
        step();
        job_valid = 1'b0;
        n_compared++; if ({o_load, o_solve, o_busy} !== 3'b001) begin n_mismatched++; $display("FAIL arst_load: got %b want 001", {o_load, o_solve, o_busy}); end
        step();
        n_compared++; if ({o_load, o_solve} !== 2'b11) begin n_mismatched++; $display("FAIL arst_solve: got %b want 11", {o_load, o_solve}); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        consume();
    endtask

    task automatic test_back_to_back();
        start_job({8{32'hABAB_0001}}, {16{32'hCDCD_0002}});
        abort = 1'b1;
        step();
        abort = 1'b0;
        job_valid = 1'b1;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        n_compared++; if ({o_res_valid, o_busy, o_job_ready} !== 3'b001) begin n_mismatched++; $display("FAIL b2b_gap: got %b want 001", {o_res_valid, o_busy, o_job_ready}); end
        step();
        job_valid = 1'b0;
        n_compared++; if ({o_busy, o_job_ready, o_load} !== 3'b100) begin n_mismatched++; $display("FAIL b2b_accept: got %b want 100", {o_busy, o_job_ready, o_load}); end
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        consume();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        sel       = 1'b0;
        job_valid = 1'b0;
        job_mid   = '0;
        job_head  = '0;
        abort     = 1'b0;
        res_ready = 1'b0;
        sha_flag  = 1'b0;
        sha_nonce = 32'd0;
        test_reset();
        test_found();
        test_warmup();
        test_tie();
        test_abort();
        test_backpressure();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/sha_job_controller.md
Name: sha_job_controller

Overview:
- Sequences one sha_block instance through load, search and report phases for each mining job.
- Accepts jobs (midstate plus header block) from the host-side interface over a valid/ready handshake and holds them stable for the whole search.
- Drives sha_block loadState/solveEn, watches its flag/goldenNonce and returns one result per job: either a found nonce or "exhausted".
- Sits between the host/UART command layer and sha_block.

Parameters:
- SEARCH_LIMIT, 32'hFFFF_FFFF, number of SOLVE-state clock cycles before the job is declared exhausted; 1 or greater.
- WARMUP, 2, SOLVE cycles after entry during which the sha_block flag is ignored (output manager drain); 0 to 15.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- n_rst  in  1  asynchronous active-low reset.
- job_valid  in  1  host offers a job.
- job_ready  out  1  controller accepts the job this cycle when job_valid=1.
- job_mid  in  256  job midstate.
- job_head  in  512  job header block.
- abort  in  1  cancel the current job.
- mid_state  out  256  registered midstate to sha_block.
- head_data  out  512  registered header to sha_block.
- load_state  out  1  to sha_block loadState; 0 holds its counters cleared.
- solve_en  out  1  to sha_block solveEn.
- sha_flag  in  1  sha_block flag.
- sha_nonce  in  32  sha_block goldenNonce.
- res_valid  out  1  result available.
- res_ready  in  1  host consumes the result.
- res_found  out  1  1 = nonce found, 0 = exhausted or aborted.
- res_nonce  out  32  golden nonce when res_found=1, else 0.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (n_rst=0, async): state=IDLE.
  - job_ready=0, load_state=0, solve_en=0, res_valid=0, res_found=0, res_nonce=0, busy=0.
  - mid_state and head_data are cleared to 0.
  - The cycle counter and warmup counter are cleared.
  - A reset during any state discards the job and its result with no report.
- All outputs are registered except job_ready, which is a decode of state==IDLE.
- IDLE:
  - job_ready=1; load_state=0; solve_en=0.
  - When job_valid=1, latch job_mid/job_head into mid_state/head_data, go to LOAD.
  - abort is ignored in IDLE.
- LOAD (exactly 1 cycle):
  - load_state=0, solve_en=0, so the sha_block counters are cleared with the new data stable.
  - Clear the cycle counter; load the warmup counter with WARMUP.
  - Go to SOLVE.
- SOLVE:
  - load_state=1 and solve_en=1, both registered so they are high from the first SOLVE cycle.
  - The cycle counter increments every cycle. The warmup counter decrements to 0 and saturates there.
  - Priority, evaluated each cycle:
    1. abort: res_found=0, res_nonce=0, go to REPORT.
    2. sha_flag=1 and warmup counter is 0: capture sha_nonce into res_nonce, res_found=1, go to REPORT.
    3. cycle counter == SEARCH_LIMIT-1: res_found=0, res_nonce=0, go to REPORT.
  - sha_flag while the warmup counter is nonzero is ignored.
  - A flag and the limit in the same cycle resolve as found.
- REPORT:
  - load_state=0, solve_en=0, res_valid=1; result outputs stay stable until consumed.
  - res_valid&res_ready: res_valid=0 next cycle, go to IDLE.
  - abort in REPORT is ignored; the result is still delivered.
  - res_ready asserted outside REPORT has no effect.
- Latency and counters:
  - Job accept to the first solve_en=1 cycle: 2 cycles (IDLE→LOAD→SOLVE).
  - Flag to res_valid: 1 cycle.
  - The cycle counter is 32-bit and does not wrap; the terminal compare stops it.
  - With SEARCH_LIMIT=1, the job exhausts on its first SOLVE cycle unless aborted or flagged (warmup permitting).
- busy=1 in LOAD, SOLVE and REPORT.
- A new job is accepted only in IDLE. Back-to-back jobs with job_valid held high give 1 idle cycle between a result handshake and the next accept.

Test Plan:
- Found: reset; apply a job with SEARCH_LIMIT=100, WARMUP=2; pulse sha_flag=1 with sha_nonce=32'h1234_ABCD on SOLVE cycle 5 → res_valid=1 next cycle, res_found=1, res_nonce=32'h1234_ABCD, solve_en=0; after res_ready, IDLE and job_ready=1.
- Warmup mask: WARMUP=2, sha_flag=1 on SOLVE cycles 0–1 only → ignored; job exhausts after exactly 100 SOLVE cycles with res_found=0, res_nonce=0.
- Exhaustion/tie: SEARCH_LIMIT=8, sha_flag=1 on SOLVE cycle 7 → res_found=1 (found wins). Same with no flag → res_found=0 after exactly 8 solve_en cycles.
- Abort: abort on SOLVE cycle 3 together with sha_flag=1 → res_found=0, res_nonce=0. Abort held in REPORT → the result is still delivered unchanged.
- Backpressure and stability: hold res_ready=0 for 10 cycles in REPORT → res_valid, res_found and res_nonce stay constant; job_ready=0; a new job_valid is not accepted.
- Async reset mid-SOLVE: drop n_rst between edges → all outputs go to 0 immediately, with no result reported. After release, a new job produces load_state=0 for 1 cycle, then solve_en=1.
